rab_lookup_queue: RTL

RAB_LOOKUP_QUEUE -- requirements
Module: rab_lookup_queue

---
 rtl/rab_lookup_pkg.sv | 44 ++++
 rtl/rab_rr_arb.sv | 29 ++
 rtl/rab_lookup_queue.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rab_lookup_pkg.sv
// ---------------------------------------------------------------------------
// rab_lookup_pkg
// Shared types for the RAB lookup result queue.
//   state_t   : occupancy state of the result queue (EMPTY / PARTIAL / FULL)
//   verdict_t : per-entry verdict and flag bits captured at push time
//   make_verdict() : folds the raw TLB result bits into a verdict_t
// ---------------------------------------------------------------------------
package rab_lookup_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  typedef struct packed {
    logic accept;
    logic miss;
    logic multi;
    logic prot;
    logic prefetch;
    logic cache_coherent;
  } verdict_t;

  // A lookup is accepted only on a single clean hit with permission and no
  // prefetch marking; the prefetch flag is only meaningful on a hit.
  function automatic verdict_t make_verdict(
    input logic no_hit,
    input logic multiple_hit,
    input logic no_prot,
    input logic prefetch,
    input logic cache_coherent
  );
    verdict_t v;
    v.accept         = ~(no_hit | multiple_hit | ~no_prot | prefetch);
    v.miss           = no_hit;
    v.multi          = multiple_hit;
    v.prot           = ~no_prot;
    v.prefetch       = ~no_hit & prefetch;
    v.cache_coherent = cache_coherent;
    return v;
  endfunction

endpackage

// File: rtl/rab_rr_arb.sv
// ---------------------------------------------------------------------------
// rab_rr_arb
// Combinational round-robin arbiter: grants the first requester at or after
// ptr_i (wrapping), or nothing when no request is raised.
//   req_i   in  NUM_REQ  request vector
//   ptr_i   in  PTR_W    highest-priority index this cycle
//   grant_o out NUM_REQ  one-hot grant (or zero)
// ---------------------------------------------------------------------------
module rab_rr_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [NUM_REQ-1:0] req_rot;
  logic [NUM_REQ-1:0] grant_rot;

  // Rotate the requests so ptr_i lands at bit 0, pick the lowest set bit,
  // then rotate the single grant bit back to its real position.
  always_comb begin
    req_rot   = NUM_REQ'({req_i, req_i} >> ptr_i);
    grant_rot = req_rot & ~(req_rot - NUM_REQ'(1));
    grant_o   = NUM_REQ'(({grant_rot, grant_rot} << ptr_i) >> NUM_REQ);
  end

endmodule

// File: rtl/rab_lookup_queue.sv
// ---------------------------------------------------------------------------
// rab_lookup_queue
// Arbitrates TLB lookups from NUM_PORTS slave ports and queues each result
// until the owning port reports it has consumed it. Each port has at most
// one entry in flight.
//   Clk_CI, Rst_RBI             clock, synchronous active-low reset
//   port_addr_valid_i / port_grant_o   per-port request / one-hot grant
//   no_hit_i .. in_user_i       lookup result + request data of granted port
//   port_sent_i                 owning port has consumed the head result
//   port_accept/drop/miss_o     head verdict, one-hot at owning port
//   miss_o .. in_user_o         head entry flags and fields (0 when empty)
//   valid_o, count_o            head present, occupancy
// ---------------------------------------------------------------------------
module rab_lookup_queue
  import rab_lookup_pkg::*;
#(
  parameter int unsigned NUM_PORTS        = 2,
  parameter int unsigned QUEUE_DEPTH      = 2,
  parameter int unsigned AXI_M_ADDR_WIDTH = 40,
  parameter int unsigned AXI_S_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH     = 8,
  parameter int unsigned AXI_USER_WIDTH   = 6
) (
  input  logic                             Clk_CI,
  input  logic                             Rst_RBI,
  input  logic [NUM_PORTS-1:0]             port_addr_valid_i,
  output logic [NUM_PORTS-1:0]             port_grant_o,
  input  logic                             no_hit_i,
  input  logic                             multiple_hit_i,
  input  logic                             no_prot_i,
  input  logic                             prefetch_i,
  input  logic                             cache_coherent_i,
  input  logic [AXI_M_ADDR_WIDTH-1:0]      out_addr_i,
  input  logic [AXI_S_ADDR_WIDTH-1:0]      in_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]          in_id_i,
  input  logic [AXI_USER_WIDTH-1:0]        in_user_i,
  input  logic [NUM_PORTS-1:0]             port_sent_i,
  output logic [NUM_PORTS-1:0]             port_accept_o,
  output logic [NUM_PORTS-1:0]             port_drop_o,
  output logic [NUM_PORTS-1:0]             port_miss_o,
  output logic                             miss_o,
  output logic                             multi_o,
  output logic                             prot_o,
  output logic                             prefetch_o,
  output logic                             cache_coherent_o,
  output logic [AXI_M_ADDR_WIDTH-1:0]      out_addr_o,
  output logic [AXI_S_ADDR_WIDTH-1:0]      in_addr_o,
  output logic [AXI_ID_WIDTH-1:0]          in_id_o,
  output logic [AXI_USER_WIDTH-1:0]        in_user_o,
  output logic                             valid_o,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] count_o
);

  localparam int unsigned PORT_W = $clog2(NUM_PORTS);
  localparam int unsigned PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH+1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PORT_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0] pending_q, pending_d;

  // Entry storage (plain register array, no reset: only slots between the
  // read and write pointers are ever observed, and outputs are gated).
  logic [PORT_W-1:0]           ent_port_q     [QUEUE_DEPTH];
  verdict_t                    ent_verdict_q  [QUEUE_DEPTH];
  logic [AXI_M_ADDR_WIDTH-1:0] ent_out_addr_q [QUEUE_DEPTH];
  logic [AXI_S_ADDR_WIDTH-1:0] ent_in_addr_q  [QUEUE_DEPTH];
  logic [AXI_ID_WIDTH-1:0]     ent_id_q       [QUEUE_DEPTH];
  logic [AXI_USER_WIDTH-1:0]   ent_user_q     [QUEUE_DEPTH];

  logic [NUM_PORTS-1:0] arb_grant;
  logic [NUM_PORTS-1:0] pop_mask;
  logic [PORT_W-1:0]    grant_idx;
  logic [PORT_W-1:0]    head_port;
  verdict_t             head_verdict;
  logic                 push;
  logic                 pop;

  rab_rr_arb #(
    .NUM_REQ (NUM_PORTS),
    .PTR_W   (PORT_W)
  ) u_arb (
    .req_i   (port_addr_valid_i & ~pending_q),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant)
  );

  // Grant / push / pop decisions. A full queue blocks the grant even when
  // the head pops this same cycle, keeping the grant path off the pop path.
  always_comb begin
    port_grant_o = (Rst_RBI && (state_q != FULL)) ? arb_grant : '0;
    push         = |port_grant_o;
    grant_idx    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_grant_o[p]) grant_idx = PORT_W'(p);
    end
    valid_o      = (state_q != EMPTY);
    head_port    = ent_port_q[rd_ptr_q];
    head_verdict = ent_verdict_q[rd_ptr_q];
    pop          = valid_o && port_sent_i[head_port];
    pop_mask     = pop ? (NUM_PORTS'(1) << head_port) : '0;
  end

  // Next-state logic for pointers, occupancy, pending bits and the FSM.
  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rr_ptr_d  = rr_ptr_q;
    state_d   = state_q;
    // A granted port is never pending, and the popped port always is, so the
    // set and clear masks never overlap.
    pending_d = (pending_q & ~pop_mask) | port_grant_o;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      rr_ptr_d = (grant_idx == PORT_W'(NUM_PORTS-1)) ? '0 : grant_idx + PORT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    case (state_q)
      EMPTY: begin
        if (push) state_d = PARTIAL;
      end
      PARTIAL: begin
        if (push && !pop && (count_q == CNT_W'(QUEUE_DEPTH-1))) begin
          state_d = FULL;
        end else if (pop && !push && (count_q == CNT_W'(1))) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) state_d = PARTIAL;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_q   <= EMPTY;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rr_ptr_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (push) begin
      ent_port_q[wr_ptr_q]     <= grant_idx;
      ent_verdict_q[wr_ptr_q]  <= make_verdict(no_hit_i, multiple_hit_i, no_prot_i,
                                               prefetch_i, cache_coherent_i);
      ent_out_addr_q[wr_ptr_q] <= out_addr_i;
      ent_in_addr_q[wr_ptr_q]  <= in_addr_i;
      ent_id_q[wr_ptr_q]       <= in_id_i;
      ent_user_q[wr_ptr_q]     <= in_user_i;
    end
  end

  // Head-entry outputs, forced to zero whenever the queue is empty.
  always_comb begin
    count_o          = count_q;
    miss_o           = valid_o & head_verdict.miss;
    multi_o          = valid_o & head_verdict.multi;
    prot_o           = valid_o & head_verdict.prot;
    prefetch_o       = valid_o & head_verdict.prefetch;
    cache_coherent_o = valid_o & head_verdict.cache_coherent;
    out_addr_o       = valid_o ? ent_out_addr_q[rd_ptr_q] : '0;
    in_addr_o        = valid_o ? ent_in_addr_q[rd_ptr_q]  : '0;
    in_id_o          = valid_o ? ent_id_q[rd_ptr_q]       : '0;
    in_user_o        = valid_o ? ent_user_q[rd_ptr_q]     : '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_accept_o[p] = valid_o && head_verdict.accept  && (head_port == PORT_W'(p));
      port_drop_o[p]   = valid_o && !head_verdict.accept && (head_port == PORT_W'(p));
      port_miss_o[p]   = valid_o && head_verdict.miss    && (head_port == PORT_W'(p));
    end
  end

endmodule
